// File: rtl/usb_pkg.sv
// Shared definitions for the USB command-frame parser: state encoding,
// error codes and the default frame-start marker.
package usb_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;

endpackage

// File: rtl/usb_cmd_parser_if.sv
// Word streams around the parser: FIFO words in, payload words out.
// The slave modport is the parser side; the master modport is the FIFO/sink side.
interface usb_cmd_parser_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/usb_cmd_parser.sv
// Locates sync-framed command packets in the EP2 OUT word stream, forwards
// payload through a one-entry output register and reports cmd/status pulses.
//
// state   | meaning
// HUNT    | discarding words until SYNC_WORD is accepted
// HEADER  | waiting for {cmd, len}
// PAYLOAD | forwarding len words to the sink
// CHECK   | comparing the checksum word with the accumulator
module usb_cmd_parser
  import usb_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          MAX_LEN   = 64,
  parameter int          TIMEOUT   = 1024
) (
  input  logic               CLKOUT,
  input  logic               rst_n,
  usb_cmd_parser_if.slave    bus,
  output logic [7:0]         cmd,
  output logic               cmd_valid,
  output logic               frame_ok,
  output logic               frame_err,
  output logic [1:0]         err_code
);

  localparam int            TW         = $clog2(TIMEOUT);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN_W  = 8'(MAX_LEN);

  state_t        state, state_n;
  logic [7:0]    len_cnt, len_n;
  logic [15:0]   acc, acc_n;
  logic [TW-1:0] idle, idle_n;
  logic [15:0]   odata, odata_n;
  logic          ovalid, ovalid_n;
  logic          olast, olast_n;
  logic [7:0]    cmd_n;
  logic          cmd_valid_n, ok_n, err_n;
  logic [1:0]    code_n;
  logic          in_ready_c, accept, timeout;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = odata;
  assign bus.out_valid = ovalid;
  assign bus.out_last  = olast;

  always_ff @(posedge CLKOUT or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      len_cnt   <= '0;
      acc       <= '0;
      idle      <= '0;
      odata     <= '0;
      ovalid    <= 1'b0;
      olast     <= 1'b0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_n;
      len_cnt   <= len_n;
      acc       <= acc_n;
      idle      <= idle_n;
      odata     <= odata_n;
      ovalid    <= ovalid_n;
      olast     <= olast_n;
      cmd       <= cmd_n;
      cmd_valid <= cmd_valid_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      err_code  <= code_n;
    end
  end

  always_comb begin
    state_n     = state;
    len_n       = len_cnt;
    acc_n       = acc;
    idle_n      = '0;
    odata_n     = odata;
    ovalid_n    = ovalid;
    olast_n     = olast;
    cmd_n       = cmd;
    cmd_valid_n = 1'b0;
    ok_n        = 1'b0;
    err_n       = 1'b0;
    code_n      = err_code;

    // The output register may drain and refill in the same cycle.
    in_ready_c = (state == ST_PAYLOAD) ? (~ovalid | bus.out_ready) : 1'b1;
    accept     = bus.in_valid & in_ready_c;
    timeout    = (state != ST_HUNT) && !accept && (idle == IDLE_LIMIT);

    if (ovalid && bus.out_ready) begin
      ovalid_n = 1'b0;
      olast_n  = 1'b0;
    end

    if (state != ST_HUNT && !accept) idle_n = idle + 1'b1;

    case (state)
      ST_HUNT: begin
        if (accept && bus.in_data == SYNC_WORD) state_n = ST_HEADER;
      end
      ST_HEADER: begin
        if (accept) begin
          cmd_n       = bus.in_data[15:8];
          cmd_valid_n = 1'b1;
          acc_n       = bus.in_data;
          if (bus.in_data[7:0] > MAX_LEN_W) begin
            err_n   = 1'b1;
            code_n  = ERR_LEN;
            state_n = ST_HUNT;
          end else if (bus.in_data[7:0] == 8'd0) begin
            state_n = ST_CHECK;
          end else begin
            len_n   = bus.in_data[7:0];
            state_n = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          odata_n  = bus.in_data;
          ovalid_n = 1'b1;
          olast_n  = (len_cnt == 8'd1);
          acc_n    = acc + bus.in_data;
          len_n    = len_cnt - 8'd1;
          if (len_cnt == 8'd1) state_n = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (bus.in_data == acc) begin
            ok_n = 1'b1;
          end else begin
            err_n  = 1'b1;
            code_n = ERR_CSUM;
          end
          state_n = ST_HUNT;
        end
      end
      default: state_n = ST_HUNT;
    endcase

    // timeout already excludes an accept, so it never overrides one
    if (timeout) begin
      err_n   = 1'b1;
      code_n  = ERR_TIMEOUT;
      state_n = ST_HUNT;
    end
  end

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Directed frames with a queue scoreboard; monitors compare outputs and
// status pulses against hand-computed expectations.
module tb_usb_cmd_parser;
  import usb_pkg::*;

  logic       CLKOUT;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_valid, frame_ok, frame_err;
  logic [1:0] err_code;

  usb_cmd_parser_if bus();

  usb_cmd_parser #(.SYNC_WORD(16'hA55A), .MAX_LEN(64), .TIMEOUT(1024)) dut (
    .CLKOUT    (CLKOUT),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  initial CLKOUT = 1'b0;
  always #5 CLKOUT = ~CLKOUT;

  int errors = 0;
  int checks = 0;

  logic [16:0] exp_out[$];  // {last, data}
  logic [7:0]  exp_cmd[$];
  logic [2:0]  exp_st[$];   // {is_err, code}

  logic        bp_phase = 1'b0;
  logic        held_v   = 1'b0;
  logic [16:0] held_w;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_out(input logic [15:0] d, input logic last);
    exp_out.push_back({last, d});
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge CLKOUT);
    while (!bus.in_ready && n < 300) begin
      n++;
      @(negedge CLKOUT);
    end
    if (n >= 300) check("send_stall", 32'(n), 32'd0);
    @(posedge CLKOUT);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_out.size() != 0 || exp_cmd.size() != 0 || exp_st.size() != 0) && n < limit) begin
      @(posedge CLKOUT);
      n++;
    end
    check("drain_bound", 32'(n >= limit), 32'd0);
    repeat (3) @(posedge CLKOUT);
    #1;
  endtask

  task automatic good_frame();
    push_out(16'h0001, 1'b0);
    push_out(16'h0002, 1'b0);
    push_out(16'h0003, 1'b1);
    exp_cmd.push_back(8'h03);
    exp_st.push_back({1'b0, ERR_NONE});
    send(16'hA55A); send(16'h0303);
    send(16'h0001); send(16'h0002); send(16'h0003);
    send(16'h0309);
    drain(100);
  endtask

  always @(negedge CLKOUT) begin
    if (rst_n) begin
      if (held_v) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'({bus.out_last, bus.out_data}), 32'(held_w));
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_w = {bus.out_last, bus.out_data};

      if (bp_phase && bus.out_valid && !bus.out_ready && exp_out.size() > 1)
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);

      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) check("out_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
        else check("out_word", 32'({bus.out_last, bus.out_data}), 32'(exp_out.pop_front()));
      end
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected", 32'(cmd), 32'hFFFF_FFFF);
        else check("cmd", 32'(cmd), 32'(exp_cmd.pop_front()));
      end
      if (frame_ok || frame_err) begin
        if (exp_st.size() == 0) check("status_unexpected", 32'({frame_err, err_code}), 32'hFFFF_FFFF);
        else check("status", 32'({frame_err, frame_err ? err_code : ERR_NONE}), 32'(exp_st.pop_front()));
        check("status_exclusive", 32'(frame_ok & frame_err), 32'd0);
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge CLKOUT);
    #1 rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_pulses", 32'({cmd_valid, frame_ok, frame_err}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    good_frame();

    // garbage before sync, zero-length frame
    exp_cmd.push_back(8'h07);
    exp_st.push_back({1'b0, ERR_NONE});
    send(16'h1234); send(16'hFFFF);
    send(16'hA55A); send(16'h0700); send(16'h0700);
    drain(100);

    // bad checksum: payload still forwarded
    push_out(16'h0001, 1'b0);
    push_out(16'h0002, 1'b0);
    push_out(16'h0003, 1'b1);
    exp_cmd.push_back(8'h03);
    exp_st.push_back({1'b1, ERR_CSUM});
    send(16'hA55A); send(16'h0303);
    send(16'h0001); send(16'h0002); send(16'h0003);
    send(16'h0000);
    drain(100);
    check("csum_err_code_held", 32'(err_code), 32'(ERR_CSUM));

    // len 65 > MAX_LEN; cmd still reported, then a good frame
    exp_cmd.push_back(8'h01);
    exp_st.push_back({1'b1, ERR_LEN});
    send(16'hA55A); send(16'h0141);
    drain(100);
    good_frame();

    // back-pressure: cmd 3 len 4, payload 0x10..0x13, checksum 0x034A
    push_out(16'h0010, 1'b0);
    push_out(16'h0011, 1'b0);
    push_out(16'h0012, 1'b0);
    push_out(16'h0013, 1'b1);
    exp_cmd.push_back(8'h03);
    exp_st.push_back({1'b0, ERR_NONE});
    bp_phase = 1'b1;
    fork
      begin
        send(16'hA55A); send(16'h0304);
        send(16'h0010); send(16'h0011); send(16'h0012); send(16'h0013);
        send(16'h034A);
      end
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 24; i++) begin
          @(posedge CLKOUT);
          #1 bus.out_ready = pat[3 - (i % 4)];
        end
        bus.out_ready = 1'b1;
      end
    join
    drain(100);
    bp_phase = 1'b0;

    // timeout after one payload word of a len-4 frame
    push_out(16'h0AAA, 1'b0);
    exp_cmd.push_back(8'h05);
    exp_st.push_back({1'b1, ERR_TIMEOUT});
    send(16'hA55A); send(16'h0504); send(16'h0AAA);
    drain(1200);
    check("timeout_err_code", 32'(err_code), 32'(ERR_TIMEOUT));

    // reset in the middle of a payload
    push_out(16'h0001, 1'b0);
    exp_cmd.push_back(8'h06);
    send(16'hA55A); send(16'h0604); send(16'h0001); send(16'h0002);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", 32'(bus.out_data), 32'd0);
    check("midrst_status", 32'({cmd, cmd_valid, frame_ok, frame_err, err_code}), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_queues", 32'(exp_out.size() + exp_cmd.size() + exp_st.size()), 32'd0);
    @(posedge CLKOUT);
    #1 rst_n = 1'b1;
    good_frame();

    check("final_queues", 32'(exp_out.size() + exp_cmd.size() + exp_st.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
